// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage MIPS-32 pipeline control slice.
//   - md_state_e     : mul/div occupancy FSM states (RUN, MD_BUSY)
//   - MUL_CYCLES_DEF : default EX occupancy of MULT/MULTU, start cycle included
//   - DIV_CYCLES_DEF : default EX occupancy of DIV/DIVU, start cycle included
//   - NOP_INSTR      : encoding the flush paths load into IF/ID (sll $0,$0,0)
//   - md_load_value  : busy-counter preload for a given mul/div kind
// ---------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_e;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Busy counter preload: the start cycle itself is not counted.
    function automatic int md_load_value(input logic is_div, input int mul_cycles,
                                         input int div_cycles);
        if (is_div) begin
            return div_cycles - 1;
        end else begin
            return mul_cycles - 1;
        end
    endfunction

endpackage

// File: rtl/hazard_control_unit_checker.sv
// ---------------------------------------------------------------------------
// hazard_control_unit_checker
// Simulation-only properties for the hazard control unit.
// Ports:
//   clk, rst_n         : clock and synchronous active-low reset
//   MulDiv_Busy        : mul/div unit occupied
//   ID_EX_MulDiv_Start : mul/div instruction in EX this cycle
// ---------------------------------------------------------------------------
module hazard_control_unit_checker (
    input logic clk,
    input logic rst_n,
    input logic MulDiv_Busy,
    input logic ID_EX_MulDiv_Start
);

    // A second mul/div may not reach EX while the unit is still occupied.
    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n) !(MulDiv_Busy && ID_EX_MulDiv_Start)
    );

endmodule

// File: rtl/muldiv_busy_tracker.sv
// ---------------------------------------------------------------------------
// muldiv_busy_tracker
// Tracks occupancy of the multi-cycle multiply/divide unit.
// A start moves RUN -> MD_BUSY and preloads the counter with N-1; the FSM
// returns to RUN on the edge where the counter reads 1, so busy is high for
// exactly N-1 cycles after the start cycle. A start seen while busy is
// ignored (the unit is already committed).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : mul/div instruction in EX this cycle
//   is_div : qualifies start, 1 = divide, 0 = multiply
//   busy   : registered, unit occupied
// ---------------------------------------------------------------------------
module muldiv_busy_tracker
    import pipeline_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(md_load_value(1'b0, MUL_CYCLES, DIV_CYCLES));
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(md_load_value(1'b1, MUL_CYCLES, DIV_CYCLES));

    md_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    // Occupancy FSM, countdown and registered busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (start) begin
                        state_r <= ST_MD_BUSY;
                        cnt_r   <= is_div ? DIV_LOAD : MUL_LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_MD_BUSY: begin
                    // Starts are ignored here; branches never cancel the unit.
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_MD_BUSY;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
// Stall/flush controller at the decode/execute boundary of the MIPS-32
// pipeline. Detects load-use hazards forwarding cannot cover, holds back
// HI/LO readers and new mul/div ops while the mul/div unit is occupied, and
// flushes the wrong-path instructions when a branch resolves taken.
// Optional feature: define HAZARD_STATS_EN to add the Stall_Cycles counter.
// Ports:
//   clk, rst_n                   : clock, synchronous active-low reset
//   ID_EX_MemRead, ID_EX_Reg_Rt  : load in EX and its destination
//   IF_ID_Reg_Rs, IF_ID_Reg_Rt   : sources of the ID instruction
//   IF_ID_Uses_Rt                : ID instruction reads Rt
//   IF_ID_Reads_HiLo             : ID instruction is MFHI/MFLO
//   IF_ID_Is_MulDiv              : ID instruction is a mul/div
//   ID_EX_MulDiv_Start, ID_EX_Is_Div : mul/div starting in EX, kind
//   Branch_Taken                 : branch/jump resolved taken in EX
//   PC_Write, IF_ID_Write        : load enables (low during a stall)
//   IF_ID_Flush, ID_EX_Flush     : bubble controls
//   MulDiv_Busy                  : registered, mul/div unit occupied
//   Stall_Cycles                 : saturating stall count (HAZARD_STATS_EN)
// ---------------------------------------------------------------------------
module hazard_control_unit
    import pipeline_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_Reg_Rt,
    input  logic [4:0] IF_ID_Reg_Rs,
    input  logic [4:0] IF_ID_Reg_Rt,
    input  logic       IF_ID_Uses_Rt,
    input  logic       IF_ID_Reads_HiLo,
    input  logic       IF_ID_Is_MulDiv,
    input  logic       ID_EX_MulDiv_Start,
    input  logic       ID_EX_Is_Div,
    input  logic       Branch_Taken,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       MulDiv_Busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] Stall_Cycles
`endif
);

    logic busy_s;
    logic load_use_s;
    logic md_hazard_s;
    logic stall_s;

    muldiv_busy_tracker #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_tracker (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (ID_EX_MulDiv_Start),
        .is_div (ID_EX_Is_Div),
        .busy   (busy_s)
    );

    hazard_control_unit_checker u_checker (
        .clk                (clk),
        .rst_n              (rst_n),
        .MulDiv_Busy        (busy_s),
        .ID_EX_MulDiv_Start (ID_EX_MulDiv_Start)
    );

    assign MulDiv_Busy = busy_s;

    // Hazard detection and pipeline control; a taken branch overrides any stall
    // because the ID instruction is on the wrong path.
    always_comb begin
        load_use_s  = 1'b0;
        md_hazard_s = 1'b0;
        stall_s     = 1'b0;
        if (ID_EX_MemRead && (ID_EX_Reg_Rt != 5'd0) &&
            ((ID_EX_Reg_Rt == IF_ID_Reg_Rs) ||
             (IF_ID_Uses_Rt && (ID_EX_Reg_Rt == IF_ID_Reg_Rt)))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
        // A start in EX this cycle already blocks HI/LO readers behind it.
        if ((IF_ID_Reads_HiLo || IF_ID_Is_MulDiv) && (busy_s || ID_EX_MulDiv_Start)) begin
            md_hazard_s = 1'b1;
        end else begin
            md_hazard_s = 1'b0;
        end
        if ((load_use_s || md_hazard_s) && !Branch_Taken) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
        PC_Write    = !stall_s;
        IF_ID_Write = !stall_s;
        IF_ID_Flush = Branch_Taken;
        ID_EX_Flush = stall_s || Branch_Taken;
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_r;

    // Saturating count of cycles in which the front end was held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_r <= 32'd0;
        end else if (stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign Stall_Cycles = stall_cycles_r;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
// Self-checking bench for hazard_control_unit (default parameters).
// Output vector compared each cycle: {PC_Write, IF_ID_Write, IF_ID_Flush,
// ID_EX_Flush, MulDiv_Busy}. The reference keeps the mul/div occupancy as a
// plain "cycles still busy" integer.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic       clk;
    logic       rst_n;
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rt;
    logic       reads_hilo;
    logic       is_muldiv;
    logic       md_start;
    logic       md_is_div;
    logic       br_taken;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    logic [4:0] dut_vec;
    assign dut_vec = {pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy};

    int pass_cnt  = 0;
    int total_cnt = 0;
    int md_left   = 0;
    int stats_model = 0;

    hazard_control_unit #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N),
        .CNT_W      (6)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ID_EX_MemRead      (memread),
        .ID_EX_Reg_Rt       (ex_rt),
        .IF_ID_Reg_Rs       (id_rs),
        .IF_ID_Reg_Rt       (id_rt),
        .IF_ID_Uses_Rt      (uses_rt),
        .IF_ID_Reads_HiLo   (reads_hilo),
        .IF_ID_Is_MulDiv    (is_muldiv),
        .ID_EX_MulDiv_Start (md_start),
        .ID_EX_Is_Div       (md_is_div),
        .Branch_Taken       (br_taken),
        .PC_Write           (pc_write),
        .IF_ID_Write        (if_id_write),
        .IF_ID_Flush        (if_id_flush),
        .ID_EX_Flush        (id_ex_flush),
        .MulDiv_Busy        (md_busy)
`ifdef HAZARD_STATS_EN
        ,
        .Stall_Cycles       (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: expected output vector from the current inputs and occupancy.
    function automatic logic [4:0] model_vec();
        logic busy, lu, mh, st;
        busy = (md_left > 0);
        lu = memread && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
        mh = (reads_hilo || is_muldiv) && (busy || md_start);
        st = (lu || mh) && !br_taken;
        return {!st, !st, br_taken, st || br_taken, busy};
    endfunction

    // Reference state update at a rising edge (inputs are still the pre-edge values).
    task automatic model_tick();
        logic [4:0] v;
        v = model_vec();
        if (!rst_n) begin
            md_left = 0;
            stats_model = 0;
        end else begin
            if (!v[4]) stats_model++;
            if (md_left > 0) md_left--;
            else if (md_start) md_left = (md_is_div ? DIV_N : MUL_N) - 1;
        end
    endtask

    task automatic quiet_inputs();
        memread = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; uses_rt = 1'b0;
        reads_hilo = 1'b0; is_muldiv = 1'b0; md_start = 1'b0; md_is_div = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic advance();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        quiet_inputs();
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        total_cnt++;
        if (dut_vec !== 5'b11000) $display("FAIL reset_outputs: got %b want %b", dut_vec, 5'b11000);
        else pass_cnt++;
`ifdef HAZARD_STATS_EN
        total_cnt++;
        if (stall_cycles !== 32'd0) $display("FAIL reset_stats: got %0d want 0", stall_cycles);
        else pass_cnt++;
`endif
        advance();
    endtask

    task automatic test_load_use();
        quiet_inputs();
        memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        @(negedge clk);
        total_cnt++;
        if (dut_vec !== 5'b00010) $display("FAIL load_use_rs: got %b want %b", dut_vec, 5'b00010);
        else pass_cnt++;
        advance();
        quiet_inputs();
        @(negedge clk);
        total_cnt++;
        if (dut_vec !== 5'b11000) $display("FAIL load_use_release: got %b want %b", dut_vec, 5'b11000);
        else pass_cnt++;
        advance();
        memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; uses_rt = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (dut_vec !== 5'b11000) $display("FAIL load_use_r0: got %b want %b", dut_vec, 5'b11000);
        else pass_cnt++;
        advance();
        memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; uses_rt = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (dut_vec !== 5'b11000) $display("FAIL rt_not_used: got %b want %b", dut_vec, 5'b11000);
        else pass_cnt++;
        uses_rt = 1'b1;
        #1;
        total_cnt++;
        if (dut_vec !== 5'b00010) $display("FAIL load_use_rt: got %b want %b", dut_vec, 5'b00010);
        else pass_cnt++;
        advance();
        quiet_inputs();
    endtask

    // MULT starts in cycle k=0 with MFHI waiting in ID.
    task automatic test_mul_latency();
        logic st, bz;
        for (int k = 0; k < 6; k++) begin
            quiet_inputs();
            md_start = (k == 0); md_is_div = 1'b0; reads_hilo = 1'b1;
            st = (k <= MUL_N - 1);
            bz = (k >= 1) && (k <= MUL_N - 1);
            @(negedge clk);
            total_cnt++;
            if (dut_vec !== {!st, !st, 1'b0, st, bz})
                $display("FAIL mul_latency k=%0d: got %b want %b", k, dut_vec, {!st, !st, 1'b0, st, bz});
            else pass_cnt++;
            advance();
        end
        quiet_inputs();
    endtask

    // DIV starts at k=0; a taken branch at busy cycle 5 must not cancel it.
    task automatic test_div_branch();
        logic bz;
        logic [4:0] exp;
        for (int k = 0; k < DIV_N + 2; k++) begin
            quiet_inputs();
            md_start = (k == 0); md_is_div = 1'b1;
            reads_hilo = (k == 5); br_taken = (k == 5);
            bz = (k >= 1) && (k <= DIV_N - 1);
            exp = (k == 5) ? 5'b11111 : {1'b1, 1'b1, 1'b0, 1'b0, bz};
            @(negedge clk);
            total_cnt++;
            if (dut_vec !== exp) $display("FAIL div_branch k=%0d: got %b want %b", k, dut_vec, exp);
            else pass_cnt++;
            advance();
        end
        quiet_inputs();
    endtask

    task automatic test_branch_priority();
        quiet_inputs();
        memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; br_taken = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (dut_vec !== 5'b11110) $display("FAIL branch_priority: got %b want %b", dut_vec, 5'b11110);
        else pass_cnt++;
        advance();
        quiet_inputs();
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        total_cnt++;
        if (stall_cycles !== 32'(stats_model)) $display("FAIL branch_no_count: got %0d want %0d", stall_cycles, stats_model);
        else pass_cnt++;
        advance();
`endif
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        md_start = 1'b1; md_is_div = 1'b1;
        advance();
        quiet_inputs();
        for (int k = 1; k <= 3; k++) begin
            reads_hilo = 1'b1;
            @(negedge clk);
            total_cnt++;
            if (dut_vec !== 5'b00011) $display("FAIL busy_stall k=%0d: got %b want %b", k, dut_vec, 5'b00011);
            else pass_cnt++;
            advance();
        end
        quiet_inputs();
        @(negedge clk);
        total_cnt++;
        if (dut_vec !== 5'b11001) $display("FAIL busy_before_reset: got %b want %b", dut_vec, 5'b11001);
        else pass_cnt++;
`ifdef HAZARD_STATS_EN
        total_cnt++;
        if (stall_cycles !== 32'd3) $display("FAIL stats_three: got %0d want 3", stall_cycles);
        else pass_cnt++;
`endif
        apply_reset();
        @(negedge clk);
        total_cnt++;
        if (dut_vec !== 5'b11000) $display("FAIL reset_mid_busy: got %b want %b", dut_vec, 5'b11000);
        else pass_cnt++;
`ifdef HAZARD_STATS_EN
        total_cnt++;
        if (stall_cycles !== 32'd0) $display("FAIL stats_after_reset: got %0d want 0", stall_cycles);
        else pass_cnt++;
`endif
        advance();
    endtask

    task automatic test_random();
        logic [4:0] exp;
        for (int n = 0; n < 400; n++) begin
            rst_n      = ($urandom_range(0, 59) != 0);
            memread    = $urandom_range(0, 1) == 1;
            ex_rt      = 5'($urandom_range(0, 3));
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            uses_rt    = $urandom_range(0, 1) == 1;
            reads_hilo = $urandom_range(0, 3) == 0;
            is_muldiv  = $urandom_range(0, 5) == 0;
            md_is_div  = $urandom_range(0, 3) == 0;
            md_start   = (md_left == 0) && ($urandom_range(0, 4) == 0);
            br_taken   = $urandom_range(0, 7) == 0;
            @(negedge clk);
            exp = model_vec();
            total_cnt++;
            if (dut_vec !== exp) $display("FAIL random n=%0d: got %b want %b", n, dut_vec, exp);
            else pass_cnt++;
`ifdef HAZARD_STATS_EN
            total_cnt++;
            if (stall_cycles !== 32'(stats_model))
                $display("FAIL random_stats n=%0d: got %0d want %0d", n, stall_cycles, stats_model);
            else pass_cnt++;
`endif
            advance();
        end
        rst_n = 1'b1;
        quiet_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        quiet_inputs();
        advance();
        rst_n = 1'b1;
        test_reset();
        test_load_use();
        test_mul_latency();
        test_div_branch();
        test_branch_priority();
        test_reset_mid_busy();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
